// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
//   Sink end of the VGA pixel interface. Samples hSync/vSync/RGB on each pix_en
//   strobe, recovers the raster position from the sync falling edges, locks once
//   LOCK_FRAMES consecutive frames have the expected geometry, and then forwards
//   active pixels and a per-frame 16-bit checksum. Any line or frame of the wrong
//   length while locked raises a sticky timing error and drops lock.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   pix_en            one-cycle pixel strobe; all sampling is gated by it
//   hSync, vSync      active-low syncs from the display controller
//   vga_rgb[11:0]     {R,G,B} 4 bits each
//   pix_valid         one-cycle pulse: pix_x/pix_y/pix_rgb carry an active pixel
//   pix_x[9:0]        recovered column
//   pix_y[8:0]        recovered row
//   pix_rgb[11:0]     sampled colour
//   frame_done        one-cycle pulse after the last active pixel of a locked frame
//   frame_sum[15:0]   checksum of the last completed frame
//   locked            timing locked
//   timing_err        sticky length-mismatch flag, cleared only by reset
module vga_sync_receiver #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [11:0] vga_rgb,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        locked,
  output logic        timing_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter values that mark the window edges and the last count of a line/frame.
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_LAST  = 9'(V_ACTIVE - 1);

  localparam int              CNT_W    = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t             state;
  logic               hPrev, vPrev;
  logic [9:0]         hcnt, vcnt;
  logic [CNT_W-1:0]   goodCnt;
  logic               badSeen;   // a bad line occurred in the frame being measured
  logic [15:0]        acc;
  logic               lastPend;  // last active pixel just went out; frame_done next

  logic       hFall, vFall, lineBad, frameBad, inWin, emit, isLast;
  logic [9:0] hcntNxt, vcntNxt, xNxt;
  logic [8:0] yNxt;

  assign hFall = pix_en & hPrev & ~hSync;
  assign vFall = pix_en & vPrev & ~vSync;

  // hcnt restarts at each hSync fall. vcnt restarts at vSync fall and otherwise
  // steps on hSync falls, so a coincident hSync fall does not bump row 0 to 1.
  assign hcntNxt = hFall ? 10'd0 : ((hcnt == 10'h3FF) ? hcnt : hcnt + 10'd1);
  assign vcntNxt = vFall ? 10'd0 :
                   ((hFall && vcnt != 10'h3FF) ? vcnt + 10'd1 : vcnt);

  // Lengths are judged from the count reached just before the falling edge.
  assign lineBad  = hFall && (hcnt != H_LAST);
  assign frameBad = vFall && (vcnt != V_LAST);

  // The window is evaluated on the position of the sample being taken now.
  assign inWin = (hcntNxt >= H_START) && (hcntNxt < H_END) &&
                 (vcntNxt >= V_START) && (vcntNxt < V_END);
  assign xNxt  = hcntNxt - H_START;
  assign yNxt  = 9'(vcntNxt - V_START);

  assign emit   = pix_en && (state == LOCKED) && inWin && !lineBad && !frameBad;
  assign isLast = (xNxt == X_LAST) && (yNxt == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEARCH;
      hPrev      <= 1'b1;
      vPrev      <= 1'b1;
      hcnt       <= '0;
      vcnt       <= '0;
      goodCnt    <= '0;
      badSeen    <= 1'b0;
      acc        <= '0;
      lastPend   <= 1'b0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= '0;
      frame_done <= 1'b0;
      frame_sum  <= '0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      lastPend   <= 1'b0;

      // acc already holds the last pixel by now; a lock loss in between
      // suppresses the pulse and leaves frame_sum alone.
      if (lastPend && state == LOCKED) begin
        frame_done <= 1'b1;
        frame_sum  <= acc;
      end

      if (pix_en) begin
        hPrev <= hSync;
        vPrev <= vSync;
        hcnt  <= hcntNxt;
        vcnt  <= vcntNxt;

        if (emit) begin
          pix_valid <= 1'b1;
          pix_x     <= xNxt;
          pix_y     <= yNxt;
          pix_rgb   <= vga_rgb;
          lastPend  <= isLast;
        end

        if (vFall)
          acc <= '0;
        else if (emit)
          acc <= acc + {4'd0, vga_rgb};

        case (state)
          SEARCH: begin
            if (vFall) begin
              state   <= MEASURE;
              goodCnt <= '0;
              badSeen <= 1'b0;
            end
          end
          MEASURE: begin
            if (vFall) begin
              badSeen <= 1'b0;
              if (frameBad || lineBad || badSeen) begin
                goodCnt <= '0;
              end else if (goodCnt == CNT_LAST) begin
                state   <= LOCKED;
                locked  <= 1'b1;
                goodCnt <= '0;
              end else begin
                goodCnt <= goodCnt + CNT_W'(1);
              end
            end else if (lineBad) begin
              goodCnt <= '0;
              badSeen <= 1'b1;
            end
          end
          LOCKED: begin
            if (lineBad || frameBad) begin
              state      <= SEARCH;
              locked     <= 1'b0;
              timing_err <= 1'b1;
              goodCnt    <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver
//   Scoreboard bench for vga_sync_receiver on a shrunken raster (16x11 total,
//   8x6 active) so whole frames stay short. Expected pixels and frame checksums
//   are queued as stimulus is driven and popped when the DUT emits them.
module tb_vga_sync_receiver;

  localparam int H_A = 8, H_F = 2, H_S = 3, H_B = 3;
  localparam int V_A = 6, V_F = 1, V_S = 2, V_B = 2;
  localparam int H_T = H_A + H_F + H_S + H_B;
  localparam int V_T = V_A + V_F + V_S + V_B;
  localparam int H_ST = H_S + H_B;
  localparam int V_ST = V_S + V_B;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic        hSync, vSync;
  logic [11:0] vga_rgb;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [11:0] pix_rgb;
  logic        frame_done;
  logic [15:0] frame_sum;
  logic        locked;
  logic        timing_err;

  int nCmp = 0;
  int nErr = 0;
  int doneCnt = 0;

  logic [30:0] pixQ[$];
  logic [15:0] sumQ[$];

  vga_sync_receiver #(
    .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hSync(hSync), .vSync(vSync), .vga_rgb(vga_rgb),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .frame_sum(frame_sum),
    .locked(locked), .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Outputs are compared on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (pix_valid) begin
      chk("pix_expected", 32'(pixQ.size() != 0), 32'd1);
      if (pixQ.size() != 0)
        chk("pix", {pix_y, pix_x, pix_rgb}, pixQ.pop_front());
    end
    if (frame_done) begin
      doneCnt++;
      chk("done_expected", 32'(sumQ.size() != 0), 32'd1);
      if (sumQ.size() != 0)
        chk("frame_sum", frame_sum, sumQ.pop_front());
    end
  end

  // One pixel slot: strobe on one edge, then three idle clocks (25 MHz of 100).
  task automatic doSample(input logic h, input logic v, input logic [11:0] c);
    hSync = h; vSync = v; vga_rgb = c; pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_x"}, pix_x, 0);
    chk({tag, "_y"}, pix_y, 0);
    chk({tag, "_rgb"}, pix_rgb, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_sum"}, frame_sum, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err"}, timing_err, 0);
  endtask

  // pix_en low for 1000 clocks while the other inputs thrash.
  task automatic freeze(input logic [9:0] ex, input logic [8:0] ey);
    repeat (1000) begin
      hSync = 1'($urandom); vSync = 1'($urandom); vga_rgb = 12'($urandom);
      @(posedge clk); #1;
    end
    chk("hold_x", pix_x, ex);
    chk("hold_y", pix_y, ey);
    chk("freeze_err", timing_err, 0);
    chk("freeze_locked", locked, 1);
  endtask

  // Drives one frame starting with the coincident hSync/vSync fall.
  // mode: 0 = 12'hFFF, 1 = x[3:0], 2 = random. lock: frame expected locked.
  // shortLine/freezeLine/resetLine: line index of that event, -1 for none.
  task automatic sendFrame(input int mode, input bit lock, input int shortLine,
                           input int freezeLine, input int resetLine);
    bit          live;
    bit          act;
    logic [15:0] sum;
    logic [11:0] c;
    int          lineLen, x, y;
    live = lock;
    sum  = '0;
    for (int l = 0; l < V_T; l++) begin
      lineLen = (l == shortLine) ? H_T - 1 : H_T;
      if (shortLine >= 0 && l == shortLine + 1) live = 1'b0;
      for (int p = 0; p < lineLen; p++) begin
        if (l == resetLine && p == H_ST + 2) begin
          live  = 1'b0;
          reset = 1'b1;
          @(posedge clk); #1;
          reset = 1'b0;
          chkAllZero("midreset");
        end
        x   = p - H_ST;
        y   = l - V_ST;
        act = (x >= 0) && (x < H_A) && (y >= 0) && (y < V_A);
        case (mode)
          0:       c = 12'hFFF;
          1:       c = {8'h0, x[3:0]};
          default: c = 12'($urandom);
        endcase
        if (!act) c = 12'($urandom);
        if (act && live) begin
          pixQ.push_back({9'(y), 10'(x), c});
          sum = sum + {4'd0, c};
          if (x == H_A - 1 && y == V_A - 1) sumQ.push_back(sum);
        end
        doSample(p >= H_S, l >= V_S, c);
        if (l == freezeLine && p == H_ST + 3) freeze(10'(x), 9'(y));
        if (shortLine >= 0 && l == shortLine + 1 && p == 0) begin
          chk("short_locked", locked, 0);
          chk("short_err", timing_err, 1);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; hSync = 1'b1; vSync = 1'b1; vga_rgb = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chkAllZero("reset");
    repeat (5) doSample(1'b1, 1'b1, 12'h0);

    // Acquire: first fall enters measurement, lock at the end of frame 2.
    sendFrame(0, 0, -1, -1, -1);
    sendFrame(0, 0, -1, -1, -1);
    chk("pre_lock", locked, 0);
    sendFrame(0, 1, -1, -1, -1);   // 48 * FFF wraps to 16'hFFD0
    chk("lock1", locked, 1);
    chk("lock1_err", timing_err, 0);

    // Column pattern with a long pix_en gap mid-line.
    sendFrame(1, 1, -1, V_ST + 2, -1);
    chk("post_freeze_err", timing_err, 0);

    // A 15-pixel line while locked, then relock with the error held.
    sendFrame(2, 1, V_ST + 3, -1, -1);
    sendFrame(2, 0, -1, -1, -1);
    sendFrame(2, 0, -1, -1, -1);
    chk("relock_pending", locked, 0);
    chk("relock_err_held", timing_err, 1);
    sendFrame(2, 1, -1, -1, -1);
    chk("relock", locked, 1);
    chk("relock_err", timing_err, 1);

    // Reset inside an active line, then reacquire.
    sendFrame(0, 1, -1, -1, V_ST + 1);
    sendFrame(1, 0, -1, -1, -1);
    sendFrame(1, 0, -1, -1, -1);
    chk("reacq_pending", locked, 0);
    sendFrame(0, 1, -1, -1, -1);
    chk("reacq", locked, 1);
    chk("reacq_err", timing_err, 0);

    repeat (8) @(posedge clk);
    #1;
    chk("pix_left", pixQ.size(), 0);
    chk("sum_left", sumQ.size(), 0);
    chk("done_count", doneCnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
